// File: rtl/sram_req_arbiter.sv
// Two-master to one-slave arbiter for the SRAM-like bus.
// Accepted requests are tracked in order so responses return to their issuer.
module sram_req_arbiter #(
    parameter int OUTST_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             inst_req,
    input  logic             inst_wr,
    input  logic [1:0]       inst_size,
    input  logic [31:0]      inst_addr,
    input  logic [3:0]       inst_wstrb,
    input  logic [31:0]      inst_wdata,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,

    input  logic             data_req,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [31:0]      data_addr,
    input  logic [3:0]       data_wstrb,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,

    output logic             mem_req,
    output logic             mem_wr,
    output logic [1:0]       mem_size,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_wdata,
    input  logic             mem_addr_ok,
    input  logic             mem_data_ok,
    input  logic [31:0]      mem_rdata,

    output logic [PTR_W:0]   outst_cnt,
    output logic             resp_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK_I,
        LOCK_D
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [OUTST_DEPTH-1:0] id_q;
    logic [PTR_W-1:0]       wptr;
    logic [PTR_W-1:0]       rptr;
    logic [PTR_W:0]         cnt;
    logic                   err_q;

    logic                   full;
    logic                   empty;
    logic                   gnt_i;
    logic                   gnt_d;
    logic                   push;
    logic                   pop;
    logic                   head_d;

    always_comb begin
        full  = (cnt == (PTR_W+1)'(OUTST_DEPTH));
        empty = (cnt == '0);
    end

    // A locked master keeps the port until accepted; a full tracker stalls new grants.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        unique case (state)
            LOCK_I: gnt_i = 1'b1;
            LOCK_D: gnt_d = 1'b1;
            default: begin
                if (!full) begin
                    if (data_req) begin
                        gnt_d = 1'b1;
                    end else if (inst_req) begin
                        gnt_i = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        mem_req   = (gnt_d & data_req) | (gnt_i & inst_req);
        mem_wr    = gnt_d ? data_wr    : inst_wr;
        mem_size  = gnt_d ? data_size  : inst_size;
        mem_addr  = gnt_d ? data_addr  : inst_addr;
        mem_wstrb = gnt_d ? data_wstrb : inst_wstrb;
        mem_wdata = gnt_d ? data_wdata : inst_wdata;
    end

    always_comb begin
        inst_addr_ok = mem_addr_ok & gnt_i & mem_req;
        data_addr_ok = mem_addr_ok & gnt_d & mem_req;
        push         = inst_addr_ok | data_addr_ok;
        pop          = mem_data_ok & !empty;
        head_d       = id_q[rptr];
    end

    // Responses use the head as it stood before this cycle's push.
    always_comb begin
        inst_data_ok = pop & !head_d;
        data_data_ok = pop & head_d;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        outst_cnt    = cnt;
        resp_err     = err_q;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (gnt_d && !mem_addr_ok) begin
                    state_nxt = LOCK_D;
                end else if (gnt_i && !mem_addr_ok) begin
                    state_nxt = LOCK_I;
                end
            end
            LOCK_I: begin
                if (!inst_req || mem_addr_ok) begin
                    state_nxt = IDLE;
                end
            end
            LOCK_D: begin
                if (!data_req || mem_addr_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            id_q  <= '0;
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) begin
                id_q[wptr] <= data_addr_ok;
                wptr       <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                cnt <= cnt - (PTR_W+1)'(1);
            end
            if (mem_data_ok && empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with queue-based accept/response scoreboard.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [2:0]  outst_cnt;
    logic        resp_err;

    int vectors = 0;
    int errors  = 0;

    logic [32:0] exp_acc[$];
    logic [32:0] exp_resp[$];

    sram_req_arbiter #(.OUTST_DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata),
        .outst_cnt(outst_cnt), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [32:0] act,
                       input logic [32:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every accept or response the DUT presents is matched in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (inst_addr_ok || data_addr_ok) begin
                if (exp_acc.size() == 0) begin
                    chk("accept_unexpected", {data_addr_ok, mem_addr}, '1);
                end else begin
                    chk("accept", {data_addr_ok, mem_addr}, exp_acc.pop_front());
                end
                chk("accept_both", 33'(inst_addr_ok & data_addr_ok), 33'd0);
            end
            if (inst_data_ok || data_data_ok) begin
                if (exp_resp.size() == 0) begin
                    chk("resp_unexpected", {data_data_ok, mem_rdata}, '1);
                end else begin
                    chk("resp", {data_data_ok,
                        data_data_ok ? data_rdata : inst_rdata},
                        exp_resp.pop_front());
                end
                chk("resp_both", 33'(inst_data_ok & data_data_ok), 33'd0);
            end
        end
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_in();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    function automatic logic [31:0] taddr(input int k, input logic d);
        return (d ? 32'h1C01_0000 : 32'h1C00_0000) + 32'(4 * k);
    endfunction

    task automatic set_req(input int k, input logic d);
        inst_req  = !d;
        data_req  = d;
        inst_addr = taddr(k, 1'b0);
        data_addr = taddr(k, 1'b1);
    endtask

    initial begin
        logic [9:0] pat;
        pat = 10'b0110100110;
        reset = 1'b1;
        inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_wdata = '0;
        data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0; data_wdata = '0;
        inst_addr = '0; data_addr = '0; mem_rdata = '0;
        idle_in();
        nx();
        nx();
        smp();
        chk("rst_cnt", 33'(outst_cnt), 33'd0);
        chk("rst_err", 33'(resp_err), 33'd0);
        chk("rst_req", 33'(mem_req), 33'd0);
        chk("rst_aok", 33'({inst_addr_ok, data_addr_ok}), 33'd0);
        nx();
        reset = 1'b0;

        // single read
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
        exp_acc.push_back({1'b0, 32'h1C00_0000});
        smp();
        chk("single_req", 33'(mem_req), 33'd1);
        chk("single_addr", 33'(mem_addr), 33'h1C00_0000);
        nx(); idle_in(); smp();
        chk("single_cnt1", 33'(outst_cnt), 33'd1);
        nx();
        mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C05;
        exp_resp.push_back({1'b0, 32'h0280_0C05});
        smp();
        chk("single_dok", 33'(inst_data_ok), 33'd1);
        nx(); idle_in(); smp();
        chk("single_cnt0", 33'(outst_cnt), 33'd0);

        // contention: data first, inst next cycle, responses D then I
        nx();
        inst_req = 1'b1; inst_addr = 32'h1C00_0100;
        data_req = 1'b1; data_addr = 32'h1C01_00F0; mem_addr_ok = 1'b1;
        exp_acc.push_back({1'b1, 32'h1C01_00F0});
        smp();
        chk("cont_addr_d", 33'(mem_addr), 33'h1C01_00F0);
        nx();
        data_req = 1'b0;
        exp_acc.push_back({1'b0, 32'h1C00_0100});
        smp();
        chk("cont_addr_i", 33'(mem_addr), 33'h1C00_0100);
        nx(); idle_in(); smp();
        chk("cont_cnt", 33'(outst_cnt), 33'd2);
        nx();
        mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_0001;
        exp_resp.push_back({1'b1, 32'hAAAA_0001});
        nx();
        mem_rdata = 32'hBBBB_0002;
        exp_resp.push_back({1'b0, 32'hBBBB_0002});
        nx(); idle_in(); smp();
        chk("cont_cnt0", 33'(outst_cnt), 33'd0);

        // lock on data while inst waits
        nx();
        data_req = 1'b1; data_addr = 32'h1C02_00A0; data_wr = 1'b1;
        data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
        inst_req = 1'b1; inst_addr = 32'h1C00_0200;
        for (int c = 0; c < 3; c++) begin
            smp();
            chk("lock_addr", 33'(mem_addr), 33'h1C02_00A0);
            nx();
            if (c == 0) data_req = 1'b1;
        end
        smp();
        chk("lock_wr", 33'(mem_wr), 33'd1);
        chk("lock_wstrb", 33'(mem_wstrb), 33'hF);
        chk("lock_wdata", 33'(mem_wdata), 33'h1234_5678);
        mem_addr_ok = 1'b1;
        exp_acc.push_back({1'b1, 32'h1C02_00A0});
        nx();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        exp_acc.push_back({1'b0, 32'h1C00_0200});
        smp();
        chk("lock_then_i", 33'(mem_addr), 33'h1C00_0200);
        nx(); idle_in();
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_D00D;
        exp_resp.push_back({1'b1, 32'h0000_D00D});
        nx();
        mem_rdata = 32'h0000_1111;
        exp_resp.push_back({1'b0, 32'h0000_1111});
        nx(); idle_in();

        // full tracker and pointer wrap across 10 transactions
        for (int k = 0; k < 4; k++) begin
            set_req(k, pat[k]); mem_addr_ok = 1'b1;
            exp_acc.push_back({pat[k], taddr(k, pat[k])});
            smp();
            chk("fill_cnt", 33'(outst_cnt), 33'(k));
            nx();
        end
        for (int j = 0; j < 6; j++) begin
            set_req(4 + j, pat[4 + j]); mem_addr_ok = 1'b1;
            mem_data_ok = 1'b1; mem_rdata = 32'hD000_0000 + 32'(j);
            exp_resp.push_back({pat[j], 32'hD000_0000 + 32'(j)});
            smp();
            chk("full_cnt", 33'(outst_cnt), 33'd4);
            chk("full_noreq", 33'(mem_req), 33'd0);
            nx();
            mem_data_ok = 1'b0;
            exp_acc.push_back({pat[4 + j], taddr(4 + j, pat[4 + j])});
            smp();
            chk("resume_cnt", 33'(outst_cnt), 33'd3);
            chk("resume_req", 33'(mem_req), 33'd1);
            nx();
        end
        idle_in();
        for (int j = 6; j < 10; j++) begin
            mem_data_ok = 1'b1; mem_rdata = 32'hD000_0000 + 32'(j);
            exp_resp.push_back({pat[j], 32'hD000_0000 + 32'(j)});
            nx();
        end
        idle_in(); smp();
        chk("wrap_cnt0", 33'(outst_cnt), 33'd0);

        // response with empty tracker
        nx();
        mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        smp();
        chk("err_no_iok", 33'(inst_data_ok), 33'd0);
        chk("err_no_dok", 33'(data_data_ok), 33'd0);
        chk("err_pre", 33'(resp_err), 33'd0);
        nx(); idle_in(); smp();
        chk("err_set", 33'(resp_err), 33'd1);
        chk("err_cnt", 33'(outst_cnt), 33'd0);

        // reset while locked on inst with two outstanding
        nx();
        inst_req = 1'b1; inst_addr = 32'h1C00_0300; mem_addr_ok = 1'b1;
        exp_acc.push_back({1'b0, 32'h1C00_0300});
        nx();
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h1C01_0300;
        exp_acc.push_back({1'b1, 32'h1C01_0300});
        nx();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1C00_0304;
        nx();
        data_req = 1'b1; data_addr = 32'h1C01_0304;
        smp();
        chk("locki_addr", 33'(mem_addr), 33'h1C00_0304);
        chk("locki_cnt", 33'(outst_cnt), 33'd2);
        nx();
        reset = 1'b1;
        nx();
        reset = 1'b0;
        smp();
        chk("rst2_cnt", 33'(outst_cnt), 33'd0);
        chk("rst2_err", 33'(resp_err), 33'd0);
        chk("rst2_idle", 33'(mem_addr), 33'h1C01_0304);
        nx();
        data_req = 1'b0;
        smp();
        chk("drop_noreq", 33'(mem_req), 33'd0);
        nx();
        smp();
        chk("drop_idle_i", 33'(mem_addr), 33'h1C00_0304);
        chk("drop_idle_req", 33'(mem_req), 33'd1);
        nx(); idle_in();
        nx();
        smp();
        chk("acc_q_left", 33'(exp_acc.size()), 33'd0);
        chk("resp_q_left", 33'(exp_resp.size()), 33'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
